// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// One character per start/ready handshake is serialised as
// start bit, DataBits data bits (LSB or MSB first), optional parity, StopBits stop bits.
// Bit timing comes from the shared sample_trigger pulse; each bit spans SamplesPerBit triggers.
// All outputs are registered.
module uart_tx_frame #(
    parameter int unsigned DataBits      = 8,
    parameter int unsigned ParityMode    = 0,
    parameter int unsigned StopBits      = 1,
    parameter int unsigned SamplesPerBit = 16,
    parameter int unsigned MsbFirst      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_trigger,
    input  logic [DataBits-1:0] data,
    input  logic                start,
    output logic                serial_data,
    output logic                ready,
    output logic                done
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DataBits must be in 5..9");
    end
    if (ParityMode > 2) begin : g_bad_parity_mode
        $error("uart_tx_frame: ParityMode must be 0, 1 or 2");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: StopBits must be 1 or 2");
    end
    if (SamplesPerBit == 0 || SamplesPerBit > 256) begin : g_bad_samples
        $error("uart_tx_frame: SamplesPerBit must be in 1..256");
    end
    if (MsbFirst > 1) begin : g_bad_msb_first
        $error("uart_tx_frame: MsbFirst must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // Frame geometry
    // ------------------------------------------------------------------
    localparam int unsigned ParityBits = (ParityMode != 0) ? 1 : 0;
    localparam int unsigned FrameBits  = 1 + DataBits + ParityBits + StopBits;
    // Bit index runs 0..FrameBits; the extra value marks "all bits shown, stop time elapsed".
    localparam int unsigned IdxW       = $clog2(FrameBits + 1);
    localparam int unsigned CntW       = (SamplesPerBit > 1) ? $clog2(SamplesPerBit) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(SamplesPerBit - 1);
    localparam logic [IdxW-1:0] IdxEnd  = IdxW'(FrameBits);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e                 state;
    logic [CntW-1:0]        sample_cnt;
    logic [IdxW-1:0]        bit_idx;
    // Latched frame; bit 0 is the next bit to put on the line.
    logic [FrameBits-1:0]   frame_shift;

    logic                   data_parity;
    logic [FrameBits-1:0]   frame_new;
    logic                   accept;

    assign accept = (state == StIdle) && ready && start;

    // Assemble the complete frame (start, data, parity, stop) from the current data input
    always_comb begin
        frame_new    = '1;
        frame_new[0] = 1'b0;
        for (int i = 0; i < int'(DataBits); i++) begin
            frame_new[1 + i] = (MsbFirst != 0) ? data[int'(DataBits) - 1 - i] : data[i];
        end
        data_parity = ^data;
        if (ParityMode == 1) begin
            frame_new[1 + DataBits] = data_parity;
        end else if (ParityMode == 2) begin
            frame_new[1 + DataBits] = ~data_parity;
        end
    end

    // Transmit FSM: accept in idle, then step through the frame on sample triggers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            ready       <= 1'b0;
            done        <= 1'b0;
            serial_data <= 1'b1;
            sample_cnt  <= '0;
            bit_idx     <= '0;
            frame_shift <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    serial_data <= 1'b1;
                    if (accept) begin
                        // A trigger coincident with acceptance is not counted
                        state       <= StSend;
                        ready       <= 1'b0;
                        frame_shift <= frame_new;
                        sample_cnt  <= '0;
                        bit_idx     <= '0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                StSend: begin
                    if (sample_trigger) begin
                        if (bit_idx == IdxEnd) begin
                            // Last stop bit has now been held for a full bit time
                            state       <= StIdle;
                            ready       <= 1'b1;
                            done        <= 1'b1;
                            serial_data <= 1'b1;
                            sample_cnt  <= '0;
                            bit_idx     <= '0;
                        end else begin
                            serial_data <= frame_shift[0];
                            if (sample_cnt == CntLast) begin
                                sample_cnt  <= '0;
                                bit_idx     <= bit_idx + 1'b1;
                                frame_shift <= {1'b1, frame_shift[FrameBits-1:1]};
                            end else begin
                                sample_cnt <= sample_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: four instances with different configurations,
// each frame checked trigger-by-trigger against a frame built from the framing rules.
module tb_uart_tx_frame;

    localparam int NDut = 4;
    localparam int CfgDb  [NDut] = '{8, 8, 8, 5};
    localparam int CfgPm  [NDut] = '{0, 1, 2, 0};
    localparam int CfgSb  [NDut] = '{1, 1, 1, 2};
    localparam int CfgSpb [NDut] = '{16, 16, 16, 4};
    localparam int CfgMsb [NDut] = '{0, 0, 0, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       start_v [NDut];
    logic [7:0] data0, data1, data2;
    logic [4:0] data3;
    logic       sd  [NDut];
    logic       rdy [NDut];
    logic       dn  [NDut];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DataBits(CfgDb[0]), .ParityMode(CfgPm[0]), .StopBits(CfgSb[0]),
        .SamplesPerBit(CfgSpb[0]), .MsbFirst(CfgMsb[0])
    ) u_dut0 (
        .clk(clk), .rst(rst), .sample_trigger(trig), .data(data0), .start(start_v[0]),
        .serial_data(sd[0]), .ready(rdy[0]), .done(dn[0])
    );

    uart_tx_frame #(
        .DataBits(CfgDb[1]), .ParityMode(CfgPm[1]), .StopBits(CfgSb[1]),
        .SamplesPerBit(CfgSpb[1]), .MsbFirst(CfgMsb[1])
    ) u_dut1 (
        .clk(clk), .rst(rst), .sample_trigger(trig), .data(data1), .start(start_v[1]),
        .serial_data(sd[1]), .ready(rdy[1]), .done(dn[1])
    );

    uart_tx_frame #(
        .DataBits(CfgDb[2]), .ParityMode(CfgPm[2]), .StopBits(CfgSb[2]),
        .SamplesPerBit(CfgSpb[2]), .MsbFirst(CfgMsb[2])
    ) u_dut2 (
        .clk(clk), .rst(rst), .sample_trigger(trig), .data(data2), .start(start_v[2]),
        .serial_data(sd[2]), .ready(rdy[2]), .done(dn[2])
    );

    uart_tx_frame #(
        .DataBits(CfgDb[3]), .ParityMode(CfgPm[3]), .StopBits(CfgSb[3]),
        .SamplesPerBit(CfgSpb[3]), .MsbFirst(CfgMsb[3])
    ) u_dut3 (
        .clk(clk), .rst(rst), .sample_trigger(trig), .data(data3), .start(start_v[3]),
        .serial_data(sd[3]), .ready(rdy[3]), .done(dn[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input int d);
        case (idx)
            0: data0 = 8'(d);
            1: data1 = 8'(d);
            2: data2 = 8'(d);
            default: data3 = 5'(d);
        endcase
    endtask

    function automatic int frame_len(input int idx);
        return 1 + CfgDb[idx] + ((CfgPm[idx] != 0) ? 1 : 0) + CfgSb[idx];
    endfunction

    // Line level for each bit position of the frame, bit 0 first on the wire
    function automatic logic [15:0] model_frame(input int idx, input int d);
        logic [15:0] f;
        int          ones;
        int          pos;
        int          b;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        pos  = 1;
        for (int i = 0; i < CfgDb[idx]; i++) begin
            if (CfgMsb[idx] != 0) b = (d >> (CfgDb[idx] - 1 - i)) & 1;
            else                  b = (d >> i) & 1;
            f[pos] = (b != 0);
            ones   = ones + b;
            pos++;
        end
        if (CfgPm[idx] == 1) f[pos] = (ones % 2) == 1;
        if (CfgPm[idx] == 2) f[pos] = (ones % 2) == 0;
        return f;
    endfunction

    // Send one frame on instance idx and check every trigger edge of it
    task automatic run_frame(input int idx, input int d, input bit disturb, input bit coinc,
                             input bit rand_gap);
        logic [15:0] f;
        int          s;
        int          fl;
        int          gap;
        logic        exp_line;
        f  = model_frame(idx, d);
        s  = CfgSpb[idx];
        fl = s * frame_len(idx);
        check($sformatf("d%0d ready_before_start", idx), rdy[idx], 1'b1);
        set_data(idx, d);
        start_v[idx] = 1'b1;
        trig = coinc;
        tick();
        start_v[idx] = 1'b0;
        trig = 1'b0;
        check($sformatf("d%0d e0_ready", idx), rdy[idx], 1'b0);
        check($sformatf("d%0d e0_line", idx), sd[idx], 1'b1);
        set_data(idx, ~d);
        repeat (2) tick();
        check($sformatf("d%0d pre_t1_line", idx), sd[idx], 1'b1);
        for (int k = 1; k <= fl + 1; k++) begin
            if (disturb && k == fl / 2) begin
                start_v[idx] = 1'b1;
                set_data(idx, int'($urandom));
            end
            trig = 1'b1;
            tick();
            trig = 1'b0;
            start_v[idx] = 1'b0;
            exp_line = (k <= fl) ? f[(k - 1) / s] : 1'b1;
            check($sformatf("d%0d line k=%0d", idx, k), sd[idx], exp_line);
            check($sformatf("d%0d done k=%0d", idx, k), dn[idx], k == fl + 1);
            check($sformatf("d%0d ready k=%0d", idx, k), rdy[idx], k == fl + 1);
            for (int j = 0; j < NDut; j++) begin
                if (j != idx) check($sformatf("d%0d idle_line", j), sd[j], 1'b1);
            end
            gap = rand_gap ? int'($urandom_range(0, 3)) : 3;
            repeat (gap) tick();
        end
        tick();
        check($sformatf("d%0d done_clear", idx), dn[idx], 1'b0);
        check($sformatf("d%0d idle_line_after", idx), sd[idx], 1'b1);
    endtask

    initial begin : main
        int n_starts;
        int n_done;
        int t_idx;
        int t_start [3];
        int budget;
        logic prev_sd;

        for (int i = 0; i < NDut; i++) start_v[i] = 1'b0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;

        // Reset values, including a trigger during reset
        rst = 1'b1;
        repeat (2) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("d%0d rst_line", i), sd[i], 1'b1);
            check($sformatf("d%0d rst_ready", i), rdy[i], 1'b0);
            check($sformatf("d%0d rst_done", i), dn[i], 1'b0);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < NDut; i++) check($sformatf("d%0d ready_rise", i), rdy[i], 1'b1);

        // Triggers in idle have no effect
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("d%0d idle_trig_line", i), sd[i], 1'b1);
            check($sformatf("d%0d idle_trig_ready", i), rdy[i], 1'b1);
        end

        // Directed frames
        run_frame(0, 'h55, 1'b0, 1'b0, 1'b0);
        run_frame(1, 'h03, 1'b0, 1'b0, 1'b0);
        run_frame(2, 'h03, 1'b0, 1'b0, 1'b0);
        run_frame(3, 'h10, 1'b0, 1'b0, 1'b0);
        run_frame(0, 'h3C, 1'b1, 1'b0, 1'b0);
        run_frame(3, 'h0B, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a frame
        set_data(0, 'h00);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int k = 1; k <= 49; k++) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            repeat (3) tick();
        end
        check("abort line_before_rst", sd[0], 1'b0);
        rst  = 1'b1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("abort line", sd[0], 1'b1);
        check("abort ready", rdy[0], 1'b0);
        check("abort done", dn[0], 1'b0);
        tick();
        check("abort done_held", dn[0], 1'b0);
        rst = 1'b0;
        tick();
        check("abort ready_rise", rdy[0], 1'b1);
        run_frame(0, 'hA5, 1'b0, 1'b0, 1'b0);

        // start held high for three back-to-back frames
        set_data(0, 'hFF);
        start_v[0] = 1'b1;
        n_starts = 0;
        n_done   = 0;
        t_idx    = 0;
        prev_sd  = sd[0];
        budget   = 3 * (16 * 10 + 1) + 40;
        while (n_done < 3 && t_idx < budget) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            t_idx++;
            if (dn[0]) n_done++;
            if (prev_sd && !sd[0]) begin
                if (n_starts < 3) t_start[n_starts] = t_idx;
                n_starts++;
                if (n_starts == 3) start_v[0] = 1'b0;
            end
            prev_sd = sd[0];
            for (int g = 0; g < 3; g++) begin
                tick();
                if (dn[0]) n_done++;
            end
        end
        start_v[0] = 1'b0;
        check("b2b within_budget", t_idx < budget, 1'b1);
        check("b2b start_count", n_starts == 3, 1'b1);
        check("b2b done_count", n_done == 3, 1'b1);
        if (n_starts >= 3) begin
            check($sformatf("b2b gap12=%0d", t_start[1] - t_start[0]),
                  (t_start[1] - t_start[0]) == 161, 1'b1);
            check($sformatf("b2b gap23=%0d", t_start[2] - t_start[1]),
                  (t_start[2] - t_start[1]) == 161, 1'b1);
        end
        tick();
        check("b2b ready_idle", rdy[0], 1'b1);
        check("b2b line_idle", sd[0], 1'b1);

        // Randomised frames on random instances with irregular trigger spacing
        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(0, NDut - 1)), int'($urandom_range(0, 511)),
                      1'b0, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
